// File: rtl/my_uart_rx.sv
// my_uart_rx: 8N1 asynchronous serial receiver.
//
// Receives frames of one start bit (0), eight data bits LSB first and one stop
// bit (1). The line is sampled at the middle of each bit: half a bit period
// after the start edge, then once per bit period.
//
// Parameters:
//   BIT_DIV     - clk cycles per bit (8..65535)
//   SYNC_STAGES - depth of the rs232_rx synchronizer (2..3)
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   rs232_rx  - asynchronous serial input, idles high
//   rx_ack    - consumer acknowledge; clears rx_valid and overrun
//   rx_data   - last correctly received byte
//   rx_valid  - rx_data holds an unacknowledged byte
//   rx_int    - busy, high from start-bit detection until frame end
//   frame_err - one-cycle pulse when a stop bit samples low
//   overrun   - sticky, a byte completed while rx_valid was still high
module my_uart_rx #(
    parameter int unsigned BIT_DIV     = 5208,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_int,
    output logic       frame_err,
    output logic       overrun
);

    // Counter reload values; the counter counts down to 0, so N cycles load N-1.
    localparam logic [15:0] FullReload = 16'(BIT_DIV - 1);
    localparam logic [15:0] HalfReload = 16'((BIT_DIV / 2) - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   line_prev_q;
    logic                   line;
    logic                   armed;
    logic                   fall;

    state_e                 state_q;
    logic [15:0]            baud_cnt_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;

    assign line = sync_q[SYNC_STAGES-1];

    // fill_q marks when both line and line_prev_q come from real samples rather
    // than reset values, so a line held low through reset is not mistaken for a
    // start edge.
    assign armed = fill_q[SYNC_STAGES];
    assign fall  = armed & line_prev_q & ~line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '1;
            fill_q      <= '0;
            line_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], rs232_rx};
            fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            line_prev_q <= line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_int     <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // Acknowledge; a frame accepted on the same edge overrides rx_valid below.
            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (fall) begin
                        state_q    <= StStart;
                        bit_cnt_q  <= '0;
                        baud_cnt_q <= HalfReload;
                        rx_int     <= 1'b1;
                    end
                end

                StStart: begin
                    if (baud_cnt_q == 16'd0) begin
                        if (!line) begin
                            state_q    <= StData;
                            baud_cnt_q <= FullReload;
                        end else begin
                            // Glitch: line went back high before mid start bit.
                            state_q <= StIdle;
                            rx_int  <= 1'b0;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end

                StData: begin
                    if (baud_cnt_q == 16'd0) begin
                        shift_q[bit_cnt_q] <= line;
                        baud_cnt_q         <= FullReload;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end

                StStop: begin
                    if (baud_cnt_q == 16'd0) begin
                        if (line) begin
                            rx_data  <= shift_q;
                            rx_valid <= 1'b1;
                            // An ack on this edge consumes the old byte, so no overrun.
                            if (rx_valid && !rx_ack) begin
                                overrun <= 1'b1;
                            end
                            state_q <= StIdle;
                            rx_int  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state_q   <= StWaitIdle;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end

                StWaitIdle: begin
                    // Stay here through a break so it reports only one frame_err.
                    if (line) begin
                        state_q <= StIdle;
                        rx_int  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    rx_int  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_uart_rx.sv
// tb_my_uart_rx: directed testbench for my_uart_rx with BIT_DIV=16.
// Inputs change 1 time unit after a rising clk edge; outputs are read there too.
module tb_my_uart_rx;

    localparam int unsigned BitDiv = 16;

    logic       clk;
    logic       rst;
    logic       rs232_rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_int;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    my_uart_rx #(
        .BIT_DIV     (BitDiv),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs232_rx  (rs232_rx),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_int    (rx_int),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start and data bits, then puts the stop value on the line and returns
    // at its first cycle. With start driven just after edge P0, the stop bit is
    // sampled at P155 (3 cycles sync+edge, 8 half bit, 9*16).
    task automatic send_to_stop(input logic [7:0] b, input logic stop);
        rs232_rx = 1'b0;
        tick(BitDiv);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            tick(BitDiv);
        end
        rs232_rx = stop;
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_to_stop(b, 1'b1);
        tick(BitDiv);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({rx_data, rx_valid, rx_int, frame_err, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got data=%h v=%b int=%b fe=%b ov=%b, want all 0",
                     rx_data, rx_valid, rx_int, frame_err, overrun);
        end
        tick(2);
        rst = 1'b0;
        tick(5);
        checks++;
        if (rx_int !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got int=%b v=%b, want 0 0", rx_int, rx_valid);
        end
    endtask

    task automatic test_basic_a5();
        send_to_stop(8'hA5, 1'b1);
        tick(10);
        checks++;
        if (rx_valid !== 1'b0 || rx_int !== 1'b1) begin
            errors++;
            $display("FAIL a5_before_stop: got v=%b int=%b, want v=0 int=1", rx_valid, rx_int);
        end
        tick(1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL a5_accept: got v=%b data=%h, want v=1 data=a5", rx_valid, rx_data);
        end
        checks++;
        if (frame_err !== 1'b0 || rx_int !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL a5_flags: got fe=%b int=%b ov=%b, want 0 0 0",
                     frame_err, rx_int, overrun);
        end
        tick(5);
        pulse_ack();
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL a5_ack: got v=%b, want 0", rx_valid);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        rs232_rx = 1'b0;
        tick(4);
        rs232_rx = 1'b1;
        checks++;
        if (rx_int !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start: got int=%b, want 1", rx_int);
        end
        tick(8);
        checks++;
        if (rx_int !== 1'b0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: got int=%b v=%b, want 0 0", rx_int, rx_valid);
        end
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (rx_valid || frame_err || rx_int) bad++;
        end
        checks++;
        if (bad !== 0 || rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL glitch_quiet: got %0d busy/valid cycles data=%h, want 0 and a5",
                     bad, rx_data);
        end
    endtask

    task automatic test_frame_err();
        int pulses;
        pulses = 0;
        send_to_stop(8'h3C, 1'b0);
        for (int i = 0; i < BitDiv + 40; i++) begin
            tick(1);
            if (frame_err === 1'b1) pulses++;
        end
        checks++;
        if (rx_int !== 1'b1) begin
            errors++;
            $display("FAIL ferr_wait_busy: got int=%b, want 1", rx_int);
        end
        rs232_rx = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (frame_err === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ferr_pulses: got %0d, want 1", pulses);
        end
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== 8'hA5 || rx_int !== 1'b0) begin
            errors++;
            $display("FAIL ferr_state: got v=%b data=%h int=%b, want 0 a5 0",
                     rx_valid, rx_data, rx_int);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h11);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got v=%b data=%h ov=%b, want 1 11 0",
                     rx_valid, rx_data, overrun);
        end
        send_frame(8'h22);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h22 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_second: got v=%b data=%h ov=%b, want 1 22 1",
                     rx_valid, rx_data, overrun);
        end
        pulse_ack();
        checks++;
        if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_ack: got v=%b ov=%b, want 0 0", rx_valid, overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h81);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
            errors++;
            $display("FAIL rst_pre: got v=%b data=%h, want 1 81", rx_valid, rx_data);
        end
        rs232_rx = 1'b0;
        tick(BitDiv);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = 1'b1;
            tick(BitDiv);
        end
        rs232_rx = 1'b1;
        tick(BitDiv / 2);
        rst = 1'b1;
        #1;
        checks++;
        if ({rx_data, rx_valid, rx_int, frame_err, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL rst_async: got data=%h v=%b int=%b fe=%b ov=%b, want all 0",
                     rx_data, rx_valid, rx_int, frame_err, overrun);
        end
        tick(3);
        rst = 1'b0;
        tick(5);
        send_frame(8'h5A);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h5A || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_recover: got v=%b data=%h fe=%b ov=%b, want 1 5a 0 0",
                     rx_valid, rx_data, frame_err, overrun);
        end
    endtask

    task automatic test_reset_low_line();
        rs232_rx = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(40);
        checks++;
        if (rx_int !== 1'b0) begin
            errors++;
            $display("FAIL low_line_no_start: got int=%b, want 0", rx_int);
        end
        rs232_rx = 1'b1;
        tick(5);
        send_frame(8'hC3);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hC3) begin
            errors++;
            $display("FAIL low_line_recv: got v=%b data=%h, want 1 c3", rx_valid, rx_data);
        end
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        send_frame(8'h00);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL b2b_first: got v=%b data=%h, want 1 00", rx_valid, rx_data);
        end
        send_to_stop(8'hFF, 1'b1);
        tick(10);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hFF || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack_accept: got v=%b data=%h ov=%b, want 1 ff 0",
                     rx_valid, rx_data, overrun);
        end
        tick(5);
        pulse_ack();
        checks++;
        if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final_ack: got v=%b ov=%b, want 0 0", rx_valid, overrun);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rs232_rx = 1'b1;
        rx_ack   = 1'b0;
        test_reset();
        test_basic_a5();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_reset_low_line();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
